// File: rtl/hazard_pkg.sv
// Shared types for the 5-stage hazard unit: forwarding selects and MDU sequencer states.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } mdu_state_t;

endpackage

// File: rtl/mdu_stall_ctrl.sv
// Sequences the multi-cycle MDU busy window and produces the Execute-stage MDU stall.
module mdu_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int MDU_LATENCY = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic MduStartE,
   input  logic mem_stall,
   output logic mdu_stall,
   output logic MduBusy
);

   localparam int                CNT_W       = $clog2(MDU_LATENCY) + 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD    = CNT_W'(MDU_LATENCY - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
   localparam bit                MULTI_CYCLE = (MDU_LATENCY > 1);

   mdu_state_t       state_r;
   mdu_state_t       stateNext_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cntNext_s;

   // State and counter registers; reset aborts any op in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= CNT_ZERO;
      end else begin
         state_r <= stateNext_s;
         cnt_r   <= cntNext_s;
      end
   end

   // Next-state logic; the counter keeps running even while memory freezes the pipe.
   always_comb begin
      stateNext_s = state_r;
      cntNext_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (MduStartE && MULTI_CYCLE) begin
               stateNext_s = BUSY;
               cntNext_s   = CNT_LOAD;
            end else begin
               stateNext_s = IDLE;
            end
         end
         BUSY: begin
            cntNext_s = cnt_r - CNT_ONE;
            if (cnt_r <= CNT_ONE) begin
               // DONE parks a finished op that is still frozen in Execute so it cannot restart.
               if (mem_stall) begin
                  stateNext_s = DONE;
               end else begin
                  stateNext_s = IDLE;
               end
            end else begin
               stateNext_s = BUSY;
            end
         end
         DONE: begin
            if (!mem_stall) begin
               stateNext_s = IDLE;
            end else begin
               stateNext_s = DONE;
            end
         end
         default: begin
            stateNext_s = IDLE;
            cntNext_s   = CNT_ZERO;
         end
      endcase
   end

   // Stall spans the start cycle plus the BUSY cycles before the result is ready.
   always_comb begin
      mdu_stall = 1'b0;
      MduBusy   = (state_r != IDLE);
      case (state_r)
         IDLE:    mdu_stall = MduStartE && MULTI_CYCLE;
         BUSY:    mdu_stall = (cnt_r > CNT_ONE);
         DONE:    mdu_stall = 1'b0;
         default: mdu_stall = 1'b0;
      endcase
   end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage core: forwarding, load-use/MDU/memory stalls and branch flushes.
module hazard_unit_mc
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_WIDTH     = 5,
   parameter int MDU_LATENCY        = 4,
   parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
   input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
   input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
   input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
   input  logic [REG_ADDR_WIDTH-1:0] RdE,
   input  logic [REG_ADDR_WIDTH-1:0] RdM,
   input  logic [REG_ADDR_WIDTH-1:0] RdW,
   input  logic                      RegWriteM,
   input  logic                      RegWriteW,
   input  logic                      MemtoRegE,
   input  logic                      PCSrcE,
   input  logic                      MduStartE,
   input  logic                      MemReqM,
   input  logic                      MemReadyM,
   output logic                      StallF,
   output logic                      StallD,
   output logic                      StallE,
   output logic                      StallM,
   output logic                      FlushD,
   output logic                      FlushE,
   output logic                      FlushM,
   output logic                      FlushW,
   output logic [1:0]                ForwardAE,
   output logic [1:0]                ForwardBE,
   output logic                      MduBusy
);

   localparam logic [REG_ADDR_WIDTH-1:0] ZERO_IDX = {REG_ADDR_WIDTH{1'b0}};

   // Youngest producer wins: Memory is checked before Writeback.
   function automatic fwd_sel_t fwdSelect(
      input logic [REG_ADDR_WIDTH-1:0] rs,
      input logic [REG_ADDR_WIDTH-1:0] rdMem,
      input logic                      wrMem,
      input logic [REG_ADDR_WIDTH-1:0] rdWb,
      input logic                      wrWb
   );
      logic rsLive;
      rsLive = !ZERO_REG_HARDWIRED || (rs != ZERO_IDX);
      if (rsLive && wrMem && (rdMem == rs)) begin
         return FWD_MEM;
      end else if (rsLive && wrWb && (rdWb == rs)) begin
         return FWD_WB;
      end else begin
         return FWD_REG;
      end
   endfunction

   logic     memStall_s;
   logic     lwStall_s;
   logic     mduStall_s;
   logic     stallE_s;
   logic     rdELive_s;
   fwd_sel_t fwdA_s;
   fwd_sel_t fwdB_s;

   mdu_stall_ctrl #(
      .MDU_LATENCY (MDU_LATENCY)
   ) u_mdu_stall_ctrl (
      .clk       (clk),
      .rst_n     (rst_n),
      .MduStartE (MduStartE),
      .mem_stall (memStall_s),
      .mdu_stall (mduStall_s),
      .MduBusy   (MduBusy)
   );

   // Hazard detection terms shared by the stall and flush equations.
   always_comb begin
      memStall_s = MemReqM && !MemReadyM;
      rdELive_s  = !ZERO_REG_HARDWIRED || (RdE != ZERO_IDX);
      lwStall_s  = MemtoRegE && rdELive_s && ((Rs1D == RdE) || (Rs2D == RdE));
      stallE_s   = memStall_s || mduStall_s;
      fwdA_s     = fwdSelect(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      fwdB_s     = fwdSelect(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
   end

   // A frozen stage never takes a bubble; a frozen branch flushes once it finally advances.
   always_comb begin
      StallM    = memStall_s;
      StallE    = stallE_s;
      StallD    = stallE_s || lwStall_s;
      StallF    = stallE_s || lwStall_s;
      FlushW    = memStall_s;
      FlushM    = mduStall_s && !memStall_s;
      FlushE    = (lwStall_s || PCSrcE) && !stallE_s;
      FlushD    = PCSrcE && !stallE_s;
      ForwardAE = fwdA_s;
      ForwardBE = fwdB_s;
   end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Pipeline hazard unit for the 5-stage core, extended for a multi-cycle multiply/divide unit (MDU) in Execute and a data memory with a ready handshake in Memory. It produces register forwarding selects, load-use stalls and branch flushes. It also sequences the MDU busy window with an FSM and counter, and freezes the pipeline upstream of Writeback during memory wait states. Forwarding priority is youngest-first: the Memory stage wins over Writeback.

Parameters:
REG_ADDR_WIDTH, 5, register index width.
MDU_LATENCY, 4, MDU cycles from the op entering Execute to its result being valid; minimum 1, and 1 means no stall.
ZERO_REG_HARDWIRED, 1, when 1, index 0 never forwards and never causes a load-use stall.

Ports:
clk  in  1  core clock.
rst_n  in  1  asynchronous active-low reset.
Rs1D, Rs2D  in  REG_ADDR_WIDTH  source registers in Decode.
Rs1E, Rs2E, RdE  in  REG_ADDR_WIDTH  source and destination registers in Execute.
RdM, RdW  in  REG_ADDR_WIDTH  destination registers in Memory and Writeback.
RegWriteM, RegWriteW  in  1  register-write enables.
MemtoRegE  in  1  load in Execute.
PCSrcE  in  1  taken branch or jump resolved in Execute.
MduStartE  in  1  MDU op in Execute.
MemReqM  in  1  data-memory access in Memory.
MemReadyM  in  1  data memory completes this cycle.
StallF, StallD, StallE, StallM  out  1  hold the stage register.
FlushD, FlushE, FlushM, FlushW  out  1  load a bubble into the stage register.
ForwardAE, ForwardBE  out  2  00 = regfile, 01 = Memory-stage result, 10 = Writeback result.
MduBusy  out  1  the FSM is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n = 0): FSM goes to IDLE and the counter to 0. With all inputs at 0, every output is 0. Reset asserted mid-MDU aborts to IDLE immediately.
- Forwarding (combinational): ForwardAE = 01 if RegWriteM and RdM == Rs1E and Rs1E is non-zero (zero check only when ZERO_REG_HARDWIRED). Otherwise 10 if the same test passes for RdW and RegWriteW. Otherwise 00. ForwardBE is identical using Rs2E. When M and W both match, the result is 01.
- mem_stall = MemReqM and not MemReadyM.
- lw_stall = MemtoRegE and RdE is non-zero and (Rs1D == RdE or Rs2D == RdE).
- MDU FSM states are IDLE, BUSY and DONE, with counter cnt of width clog2(MDU_LATENCY) + 1.
  - IDLE: if MduStartE and MDU_LATENCY > 1, go to BUSY and load cnt = MDU_LATENCY - 1.
  - BUSY: decrement cnt each cycle. When cnt == 1, go to DONE if mem_stall, otherwise to IDLE.
  - DONE: return to IDLE on the first cycle with no mem_stall. DONE prevents a frozen MDU op from restarting.
  - mdu_stall = (IDLE and MduStartE and MDU_LATENCY > 1) or (BUSY and cnt > 1). This gives exactly MDU_LATENCY - 1 stall cycles when memory does not intervene.
  - The counter keeps running during mem_stall.
- Stall outputs:
  - StallM = mem_stall.
  - StallE = mem_stall or mdu_stall.
  - StallD = StallF = StallE or lw_stall.
- Flush outputs:
  - FlushW = mem_stall.
  - FlushM = mdu_stall and not mem_stall.
  - FlushE = (lw_stall or PCSrcE) and not StallE.
  - FlushD = PCSrcE and not StallE. A branch frozen in Execute is flushed on the cycle it finally advances.
- Simultaneous events:
  - PCSrcE together with lw_stall: FlushD and FlushE are both 1, and StallF/StallD are 1 (the PC mux overrides the stall).
  - MduStartE together with mem_stall in IDLE: the MDU starts and the pipeline is held by mem_stall.
  - mem_stall has priority over all bubble insertion upstream of Writeback.
- All outputs are combinational from the state and inputs. The only registers are the FSM state and cnt.

Decomposition:
- hazard_pkg holds fwd_sel_t (FWD_REG = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10) and mdu_state_t (IDLE, BUSY, DONE).
- One sub-module, mdu_stall_ctrl, contains the FSM and counter. Its interface is clk, rst_n, MduStartE and mem_stall in; mdu_stall and MduBusy out.

Test Plan:
- Forwarding priority: RegWriteM = RegWriteW = 1, RdM = RdW = Rs1E = 7 → ForwardAE = 01. Set RdM = 3 → ForwardAE = 10. Set Rs1E = RdM = 0 → ForwardAE = 00.
- Load-use: MemtoRegE = 1, RdE = 5, Rs2D = 5 → StallF = StallD = FlushE = 1 for one cycle. Then clear MemtoRegE → all 0.
- MDU, MDU_LATENCY = 4: MduStartE held at cycle t0 → StallE = 1 and FlushM = 1 at t0, t1, t2. At t3 StallE = 0. MduBusy is 1 at t1..t3 and 0 at t4.
- MDU overlapping a memory wait: start at t0, MemReqM = 1 and MemReadyM = 0 from t2 to t5 → FSM passes through DONE, StallE stays 1 through t5, no restart, and FSM is IDLE at t7.
- Branch during mem stall: PCSrcE = 1 while mem_stall → FlushD = FlushE = 0. On the cycle MemReadyM = 1 → FlushD = FlushE = 1.
- Reset mid-BUSY: assert rst_n = 0 at cnt = 2 → MduBusy = 0 and StallE = 0 immediately with MduStartE = 0.
